systolic_feed_sequencer: RTL and testbench
==========================================

// Module: systolic_feed_sequencer
// PURPOSE
//  Read-side sequencer between the A/B operand buffers and the systolic array; consumer of array_start, producer of data_done.
//  Walks output tiles (ARRAY_HEIGHT x ARRAY_WIDTH) and streams n operand beats per tile from both buffers.
//  Emits skewed per-row/per-column valids, per-tile accumulator clear and tile_done, and a final data_done pulse.
//  Never reads a buffer word that has not yet been written.
// PARAMETERS
//  BUFFER_ADDRESS_WIDTH  10  buffer read address width; addresses wrap modulo 2**BUFFER_ADDRESS_WIDTH
//  ARRAY_HEIGHT          4   PE rows; one A word per row tile per beat
//  ARRAY_WIDTH           4   PE columns; one B word per column tile per beat
//  READ_LATENCY          1   buffer read latency in cycles (1..3)
// PORTS
//  clk            in   1                     clock
//  reset_n        in   1                     asynchronous, active-low reset
//  array_start_i  in   1                     level from controller; rising edge starts a job
//  m, n, p        in   16                    matrix dimensions (A is m x n, B is n x p)
//  a_words_avail  in   16                    A buffer words written since job start (monotonic)
//  b_words_avail  in   16                    B buffer words written since job start (monotonic)
//  a_rd_en        out  1                     A buffer read strobe
//  a_rd_addr      out  BUFFER_ADDRESS_WIDTH  A buffer read address
//  b_rd_en        out  1                     B buffer read strobe
//  b_rd_addr      out  BUFFER_ADDRESS_WIDTH  B buffer read address
//  a_row_valid    out  ARRAY_HEIGHT          bit i: A data valid at array row i (skew i)
//  b_col_valid    out  ARRAY_WIDTH           bit j: B data valid at array column j (skew j)
//  acc_clear      out  1                     1-cycle pulse before the first beat of each tile
//  tile_done      out  1                     1-cycle pulse when a tile has fully drained
//  busy           out  1                     high from LOAD through DONE
//  data_done      out  1                     1-cycle pulse at job end (clears controller start logic)
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, counters 0. Reset mid-job aborts immediately; no data_done is produced.
//  Start: rising edge of array_start_i (registered copy used for edge detect) while in IDLE. A level held high
//   or an edge seen in any other state is ignored.
//  Tiles: RT = ceil(m/ARRAY_HEIGHT), CT = ceil(p/ARRAY_WIDTH); order is row tile r outer, column tile c inner.
//   Tile arithmetic is 32-bit internally; addresses are truncated to BUFFER_ADDRESS_WIDTH.
//  Beat k (0..n-1) of tile (r,c): A index = r*n + k, B index = c*n + k; rd_addr = index mod 2**BAW.
//  Flow control: beat k issues (both rd_en high, same cycle) only if A index < a_words_avail AND
//   B index < b_words_avail; otherwise stall with both rd_en low and indices held. The two buffers are never
//   read independently.
//  FSM:
//   IDLE   -> LOAD on start edge.
//   LOAD   (1 cycle): latch m/n/p and compute RT/CT. If m, n or p is 0 -> DONE; otherwise -> CLEAR.
//   CLEAR  (1 cycle): acc_clear=1 -> STREAM.
//   STREAM issues beats as flow control allows; after beat n-1 issues -> DRAIN.
//   DRAIN  waits READ_LATENCY + ARRAY_HEIGHT + ARRAY_WIDTH - 2 cycles, then pulses tile_done.
//          If this was the last tile -> DONE; otherwise advance c (wrap to 0 and increment r) -> CLEAR.
//   DONE   (1 cycle): data_done=1 -> IDLE.
//  Valids: base valid = rd_en delayed READ_LATENCY cycles. a_row_valid[i] = base delayed i more cycles;
//   b_col_valid[j] = base delayed j more cycles. Skew registers flush during DRAIN; all valids are 0 in DONE.
//  Latency: start edge at cycle 0 -> LOAD at 1, acc_clear at 2, first rd_en at 3 (no stall).
//  Boundaries:
//   - m or p not a multiple of the array size: the last tile still streams n beats; the padding is handled by the array.
//   - Avail counts equal to the index -> stall. Avail counts do not wrap within a job.
//   - Simultaneous start edge and DONE: the edge is ignored.
// TESTING
//  m=n=p=4, avail=16/16, READ_LATENCY=1 -> 1 tile; rd_en cycles 3..6; a_rd_addr 0,1,2,3; tile_done after
//   7 DRAIN cycles; one data_done pulse.
//  m=8, n=3, p=8 -> 4 tiles in order (0,0),(0,1),(1,0),(1,1); A idx 0-2,0-2,3-5,3-5; B idx 0-2,3-5,0-2,3-5;
//   4 acc_clear pulses and 4 tile_done pulses.
//  a_words_avail=2, n=4, then raised to 4 after 10 cycles -> rd_en stops after beat 1 and resumes with beat 2
//   once avail=4; b reads stall in lockstep.
//  n=0 -> no rd_en; data_done exactly 2 cycles after the start edge.
//  Address wrap with BAW=4, m=8, n=10, p=4: A beats of r=1 read addresses 10..15 then 0..3.
//  reset_n pulsed low in mid-STREAM -> all outputs 0 immediately; array_start_i held high afterwards -> no new job
//   until a fresh rising edge.

Source files
------------

// File: rtl/systolic_feed_sequencer.sv
// Read-side sequencer feeding the systolic array: walks output tiles, streams
// n operand beats per tile from the A/B buffers under availability flow control,
// and produces skewed row/column valids plus tile/job completion pulses.
module systolic_feed_sequencer #(
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int ARRAY_HEIGHT         = 4,
  parameter int ARRAY_WIDTH          = 4,
  parameter int READ_LATENCY         = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            array_start_i,
  input  logic [15:0]                     m,
  input  logic [15:0]                     n,
  input  logic [15:0]                     p,
  input  logic [15:0]                     a_words_avail,
  input  logic [15:0]                     b_words_avail,
  output logic                            a_rd_en,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] a_rd_addr,
  output logic                            b_rd_en,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] b_rd_addr,
  output logic [ARRAY_HEIGHT-1:0]         a_row_valid,
  output logic [ARRAY_WIDTH-1:0]          b_col_valid,
  output logic                            acc_clear,
  output logic                            tile_done,
  output logic                            busy,
  output logic                            data_done
);

  localparam int SKEW     = (ARRAY_HEIGHT > ARRAY_WIDTH) ? ARRAY_HEIGHT : ARRAY_WIDTH;
  localparam int PIPE_LEN = READ_LATENCY + SKEW - 1;
  localparam logic [7:0] DRAIN_LAST = 8'(READ_LATENCY + ARRAY_HEIGHT + ARRAY_WIDTH - 3);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]          state_q, state_d;
  logic                start_q, start_d;
  logic [31:0]         n_q, n_d;
  logic [31:0]         rt_q, rt_d;
  logic [31:0]         ct_q, ct_d;
  logic [31:0]         r_q, r_d;
  logic [31:0]         c_q, c_d;
  logic [31:0]         k_q, k_d;
  logic [31:0]         a_base_q, a_base_d;
  logic [31:0]         b_base_q, b_base_d;
  logic [7:0]          drain_q, drain_d;
  logic [PIPE_LEN-1:0] pipe_q, pipe_d;

  logic [31:0] a_idx, b_idx;
  logic        beat_ok, last_tile, start_edge, drain_end;

  // Next-state logic: FSM, tile/beat counters and the valid delay line.
  // Tile bases advance by n per tile step so r*n / c*n never need a multiplier.
  always_comb begin
    state_d    = state_q;
    start_d    = array_start_i;
    n_d        = n_q;
    rt_d       = rt_q;
    ct_d       = ct_q;
    r_d        = r_q;
    c_d        = c_q;
    k_d        = k_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    drain_d    = drain_q;
    a_idx      = a_base_q + k_q;
    b_idx      = b_base_q + k_q;
    beat_ok    = (state_q == S_STREAM) &&
                 (a_idx < {16'd0, a_words_avail}) &&
                 (b_idx < {16'd0, b_words_avail});
    last_tile  = (r_q == rt_q - 32'd1) && (c_q == ct_q - 32'd1);
    start_edge = array_start_i & ~start_q;
    drain_end  = (state_q == S_DRAIN) && (drain_q == DRAIN_LAST);

    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_LOAD;
      end
      S_LOAD: begin
        n_d      = {16'd0, n};
        rt_d     = ({16'd0, m} + 32'(ARRAY_HEIGHT - 1)) / 32'(ARRAY_HEIGHT);
        ct_d     = ({16'd0, p} + 32'(ARRAY_WIDTH - 1)) / 32'(ARRAY_WIDTH);
        r_d      = '0;
        c_d      = '0;
        k_d      = '0;
        a_base_d = '0;
        b_base_d = '0;
        state_d  = ((m == 16'd0) || (n == 16'd0) || (p == 16'd0)) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        drain_d = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (beat_ok) begin
          if (k_q == n_q - 32'd1) begin
            k_d     = '0;
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + 32'd1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          if (last_tile) begin
            state_d = S_DONE;
          end else begin
            if (c_q == ct_q - 32'd1) begin
              c_d      = '0;
              b_base_d = '0;
              r_d      = r_q + 32'd1;
              a_base_d = a_base_q + n_q;
            end else begin
              c_d      = c_q + 32'd1;
              b_base_d = b_base_q + n_q;
            end
            state_d = S_CLEAR;
          end
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pipe_d[0] = beat_ok;
    for (int unsigned i = 1; i < PIPE_LEN; i++) pipe_d[i] = pipe_q[i-1];
  end

  // State registers; start_q resets high so a level held through reset is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b1;
      n_q      <= '0;
      rt_q     <= '0;
      ct_q     <= '0;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      drain_q  <= '0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      n_q      <= n_d;
      rt_q     <= rt_d;
      ct_q     <= ct_d;
      r_q      <= r_d;
      c_q      <= c_d;
      k_q      <= k_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      drain_q  <= drain_d;
      pipe_q   <= pipe_d;
    end
  end

  // Output decode from state and the valid delay line.
  always_comb begin
    a_rd_en   = beat_ok;
    b_rd_en   = beat_ok;
    a_rd_addr = beat_ok ? a_idx[BUFFER_ADDRESS_WIDTH-1:0] : '0;
    b_rd_addr = beat_ok ? b_idx[BUFFER_ADDRESS_WIDTH-1:0] : '0;
    acc_clear = (state_q == S_CLEAR);
    tile_done = drain_end;
    busy      = (state_q != S_IDLE);
    data_done = (state_q == S_DONE);
    for (int unsigned i = 0; i < ARRAY_HEIGHT; i++) a_row_valid[i] = pipe_q[READ_LATENCY-1+i];
    for (int unsigned j = 0; j < ARRAY_WIDTH; j++)  b_col_valid[j] = pipe_q[READ_LATENCY-1+j];
  end

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Scoreboard bench for systolic_feed_sequencer: expected beat indices are
// queued at job start and popped on every read strobe.
module tb_systolic_feed_sequencer;

  localparam int BAW = 4;
  localparam int H   = 4;
  localparam int W   = 4;
  localparam int RL  = 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           array_start_i;
  logic [15:0]    m, n, p, a_av, b_av;
  logic           a_rd_en, b_rd_en, acc_clear, tile_done, busy, data_done;
  logic [BAW-1:0] a_rd_addr, b_rd_addr;
  logic [H-1:0]   a_row_valid;
  logic [W-1:0]   b_col_valid;

  systolic_feed_sequencer #(
    .BUFFER_ADDRESS_WIDTH(BAW),
    .ARRAY_HEIGHT(H),
    .ARRAY_WIDTH(W),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .array_start_i(array_start_i),
    .m(m), .n(n), .p(p), .a_words_avail(a_av), .b_words_avail(b_av),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .a_row_valid(a_row_valid), .b_col_valid(b_col_valid), .acc_clear(acc_clear),
    .tile_done(tile_done), .busy(busy), .data_done(data_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct { int unsigned a; int unsigned b; } beat_t;
  beat_t sb[$];

  int n_clr, n_tdone, n_ddone, n_rd, first_rd, last_rd, clr_cyc, tdone_cyc, ddone_cyc, busy_cnt;
  logic [15:0] hist;

  // Monitor: lockstep strobes, scoreboard addresses, skewed valids, pulse counts.
  always @(negedge clk) begin
    if (!reset_n) begin
      hist = '0;
    end else begin
      logic [H-1:0] ea;
      logic [W-1:0] eb;
      beat_t e;
      hist = {hist[14:0], a_rd_en};
      for (int i = 0; i < H; i++) ea[i] = hist[RL+i];
      for (int j = 0; j < W; j++) eb[j] = hist[RL+j];
      check("rd_en_lockstep", b_rd_en, a_rd_en);
      check("a_row_valid", 32'(a_row_valid), 32'(ea));
      check("b_col_valid", 32'(b_col_valid), 32'(eb));
      if (a_rd_en) begin
        if (sb.size() == 0) begin
          check("unexpected_rd", 1, 0);
        end else begin
          e = sb.pop_front();
          check("a_rd_addr", a_rd_addr, e.a % 16);
          check("b_rd_addr", b_rd_addr, e.b % 16);
          check("a_avail_ok", e.a < a_av, 1);
          check("b_avail_ok", e.b < b_av, 1);
        end
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (acc_clear) begin n_clr++; clr_cyc = cyc; end
      if (tile_done) begin n_tdone++; tdone_cyc = cyc; end
      if (data_done) begin
        n_ddone++;
        ddone_cyc = cyc;
        check("valids_in_done", {a_row_valid, b_col_valid}, 0);
      end
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    n_clr = 0; n_tdone = 0; n_ddone = 0; n_rd = 0; busy_cnt = 0;
    first_rd = -1; last_rd = -1; clr_cyc = -1; tdone_cyc = -1; ddone_cyc = -1;
  endtask

  // Configure a job, queue its expected beats, and raise the start level. Returns start cycle.
  task automatic start_job(input int mm, input int nn, input int pp, input int aa, input int bb,
                           output int s);
    int rt, ct;
    m = 16'(mm); n = 16'(nn); p = 16'(pp); a_av = 16'(aa); b_av = 16'(bb);
    rt = (mm + H - 1) / H;
    ct = (pp + W - 1) / W;
    sb.delete();
    if (mm != 0 && nn != 0 && pp != 0)
      for (int r = 0; r < rt; r++)
        for (int c = 0; c < ct; c++)
          for (int k = 0; k < nn; k++) begin
            beat_t e;
            e.a = r * nn + k;
            e.b = c * nn + k;
            sb.push_back(e);
          end
    clear_counts();
    array_start_i = 1'b1;
    s = cyc;
  endtask

  task automatic wait_done(input int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (data_done) got = 1'b1;
    end
    check("done_timeout", got, 1);
    @(negedge clk);
  endtask

  task automatic end_job(input int tiles);
    check("acc_clear_count", n_clr, tiles);
    check("tile_done_count", n_tdone, tiles);
    check("data_done_count", n_ddone, 1);
    check("scoreboard_empty", sb.size(), 0);
    array_start_i = 1'b0;
    step();
    step();
  endtask

  initial begin
    int s;
    reset_n = 1'b0; array_start_i = 1'b0;
    m = '0; n = '0; p = '0; a_av = '0; b_av = '0;
    clear_counts();
    repeat (3) step();
    check("reset_outputs", {a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, a_row_valid, b_col_valid,
                            acc_clear, tile_done, busy, data_done}, 0);
    reset_n = 1'b1;
    repeat (2) step();

    // Single 4x4x4 tile, no stall: latency and drain timing.
    start_job(4, 4, 4, 16, 16, s);
    wait_done(100);
    check("clear_cycle", clr_cyc, s + 2);
    check("first_rd_cycle", first_rd, s + 3);
    check("last_rd_cycle", last_rd, s + 6);
    check("beats", n_rd, 4);
    check("drain_cycles", tdone_cyc - last_rd, 7);
    check("done_after_tile", ddone_cyc, tdone_cyc + 1);
    check("busy_cycles", busy_cnt, 14);
    end_job(1);

    // Four tiles, row-tile outer, column-tile inner.
    start_job(8, 3, 8, 16, 16, s);
    wait_done(300);
    check("beats_4tiles", n_rd, 12);
    end_job(4);

    // A availability stall then release; B held in lockstep.
    start_job(4, 4, 4, 2, 16, s);
    repeat (10) step();
    check("stalled_beats", n_rd, 2);
    a_av = 16'd4;
    wait_done(100);
    check("resumed_beats", n_rd, 4);
    end_job(1);

    // n = 0 job, with a second start edge landing on DONE.
    start_job(4, 0, 4, 16, 16, s);
    step();
    array_start_i = 1'b0;
    step();
    array_start_i = 1'b1;
    repeat (8) step();
    check("n0_done_cycle", ddone_cyc, s + 2);
    check("n0_no_reads", n_rd, 0);
    check("n0_done_count", n_ddone, 1);
    check("edge_in_done_ignored", busy_cnt, 2);
    array_start_i = 1'b0;
    repeat (2) step();

    // Reset mid-STREAM with start held high afterwards.
    start_job(8, 10, 4, 100, 100, s);
    for (int i = 0; i < 50 && n_rd < 3; i++) step();
    check("reached_stream", n_rd >= 3, 1);
    reset_n = 1'b0;
    #1;
    check("midjob_reset_outputs", {a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, a_row_valid, b_col_valid,
                                   acc_clear, tile_done, busy, data_done}, 0);
    sb.delete();
    repeat (2) step();
    clear_counts();
    reset_n = 1'b1;
    repeat (20) step();
    check("no_job_after_reset", busy_cnt, 0);
    check("no_done_after_reset", n_ddone, 0);
    array_start_i = 1'b0;
    repeat (2) step();

    // Address wrap: r=1 A beats read 10..15 then 0..3.
    start_job(8, 10, 4, 100, 100, s);
    wait_done(300);
    check("wrap_beats", n_rd, 20);
    end_job(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
